seg_scan_recognizer: RTL and testbench



---
 rtl/seg_scan_recognizer_if.sv | 11 +
 rtl/seg_scan_recognizer.sv | 229 ++++++++++++++++++++++
 tb/tb_seg_scan_recognizer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_recognizer_if.sv
// Binarised pixel-stream bundle from the threshold stage into seg_scan_recognizer.
interface seg_scan_recognizer_if;
  logic        pix_en;
  logic        pix_vde;
  logic        pix_bin;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;

  modport master (output pix_en, pix_vde, pix_bin, pix_x, pix_y);
  modport slave  (input  pix_en, pix_vde, pix_bin, pix_x, pix_y);
endinterface

// File: rtl/seg_scan_recognizer.sv
// Per-slot stroke-edge counter on two scan lines and one scan column, reported once per frame.
// Optional macro SEG_EDGE_POS_EN adds the edge_pos output carrying the full last-edge x positions.
module seg_scan_recognizer #(
  parameter int NUM_SLOTS  = 3,
  parameter int SLOT_X0    = 370,
  parameter int SLOT_PITCH = 200,
  parameter int SLOT_W     = 141,
  parameter int HLINE_Y1   = 343,
  parameter int HLINE_Y2   = 376,
  parameter int VBAND_Y0   = 290,
  parameter int VBAND_Y1   = 430,
  parameter int EDGE_RUN   = 4,
  parameter int REPORT_X   = 500,
  parameter int REPORT_Y   = 500
) (
  input  logic                     clk,
  input  logic                     rst_n,
  seg_scan_recognizer_if.slave     pix,
  output logic [8*NUM_SLOTS-1:0]   codes,
  output logic                     code_valid,
  output logic                     sat_any
`ifdef SEG_EDGE_POS_EN
  ,
  output logic [22*NUM_SLOTS-1:0]  edge_pos
`endif
);
  localparam int WIN = 2 * EDGE_RUN;
  localparam logic [WIN-1:0] WIN_ONES = {WIN{1'b1}};
  localparam logic [WIN-1:0] EDGE_PAT = {{EDGE_RUN{1'b1}}, {EDGE_RUN{1'b0}}};
`ifdef SEG_EDGE_POS_EN
  localparam int LXW = 11;
`else
  localparam int LXW = 1;
`endif

  function automatic logic [10:0] slot_lo(input int s);
    return 11'(SLOT_X0 + s * SLOT_PITCH);
  endfunction

  function automatic logic [10:0] slot_hi(input int s);
    return 11'(SLOT_X0 + s * SLOT_PITCH + SLOT_W - 1);
  endfunction

  function automatic logic [10:0] slot_cx(input int s);
    return 11'(SLOT_X0 + s * SLOT_PITCH + SLOT_W / 2);
  endfunction

  // Without full positions only the "right of centre" bit of the last edge is kept.
  function automatic logic [LXW-1:0] lx_store(input logic [10:0] x, input int s);
`ifdef SEG_EDGE_POS_EN
    return x;
`else
    return x >= slot_cx(s);
`endif
  endfunction

  function automatic logic lx_ge(input logic [LXW-1:0] v, input int s);
`ifdef SEG_EDGE_POS_EN
    return v >= slot_cx(s);
`else
    return v[0];
`endif
  endfunction

  function automatic logic [1:0] bump(input logic [WIN-1:0] win, input logic [1:0] cnt);
    if ((win == EDGE_PAT) && (cnt != 2'd3)) begin
      return cnt + 2'd1;
    end else begin
      return cnt;
    end
  endfunction

  function automatic logic sat_hit(input logic [WIN-1:0] win, input logic [1:0] cnt);
    return (win == EDGE_PAT) && (cnt == 2'd3);
  endfunction

  logic [WIN-1:0] h1_win_q [NUM_SLOTS];
  logic [WIN-1:0] h1_win_d [NUM_SLOTS];
  logic [WIN-1:0] h2_win_q [NUM_SLOTS];
  logic [WIN-1:0] h2_win_d [NUM_SLOTS];
  logic [WIN-1:0] v_win_q  [NUM_SLOTS];
  logic [WIN-1:0] v_win_d  [NUM_SLOTS];
  logic [1:0]     h1_cnt_q [NUM_SLOTS];
  logic [1:0]     h1_cnt_d [NUM_SLOTS];
  logic [1:0]     h2_cnt_q [NUM_SLOTS];
  logic [1:0]     h2_cnt_d [NUM_SLOTS];
  logic [1:0]     v_cnt_q  [NUM_SLOTS];
  logic [1:0]     v_cnt_d  [NUM_SLOTS];
  logic [LXW-1:0] h1_lx_q  [NUM_SLOTS];
  logic [LXW-1:0] h1_lx_d  [NUM_SLOTS];
  logic [LXW-1:0] h2_lx_q  [NUM_SLOTS];
  logic [LXW-1:0] h2_lx_d  [NUM_SLOTS];
  logic                   sat_flag_q, sat_flag_d;
  logic [8*NUM_SLOTS-1:0] codes_q, codes_d;
  logic                   code_valid_q, code_valid_d;
  logic                   sat_any_q, sat_any_d;
`ifdef SEG_EDGE_POS_EN
  logic [22*NUM_SLOTS-1:0] edge_pos_q, edge_pos_d;
`endif

  logic                 qual_s, report_s, on_y1_s, on_y2_s, in_band_s, in_any_s;
  logic [NUM_SLOTS-1:0] in_slot_s;

  // Decode which scan structures the current pixel belongs to.
  always_comb begin
    qual_s    = pix.pix_en & pix.pix_vde;
    report_s  = qual_s & (pix.pix_x == 11'(REPORT_X)) & (pix.pix_y == 10'(REPORT_Y));
    on_y1_s   = qual_s & (pix.pix_y == 10'(HLINE_Y1));
    on_y2_s   = qual_s & (pix.pix_y == 10'(HLINE_Y2));
    in_band_s = qual_s & (pix.pix_y >= 10'(VBAND_Y0)) & (pix.pix_y <= 10'(VBAND_Y1));
    in_any_s  = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      in_slot_s[s] = (pix.pix_x >= slot_lo(s)) & (pix.pix_x <= slot_hi(s));
      in_any_s     = in_any_s | in_slot_s[s];
    end
  end

  // Window shifting, edge counting and the report/clear step.
  always_comb begin
    h1_win_d     = h1_win_q;
    h2_win_d     = h2_win_q;
    v_win_d      = v_win_q;
    h1_cnt_d     = h1_cnt_q;
    h2_cnt_d     = h2_cnt_q;
    v_cnt_d      = v_cnt_q;
    h1_lx_d      = h1_lx_q;
    h2_lx_d      = h2_lx_q;
    sat_flag_d   = sat_flag_q;
    codes_d      = codes_q;
    sat_any_d    = sat_any_q;
    code_valid_d = report_s;
`ifdef SEG_EDGE_POS_EN
    edge_pos_d   = edge_pos_q;
`endif
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (report_s) begin
        codes_d[8*s +: 8] = {h1_cnt_q[s], h2_cnt_q[s], v_cnt_q[s],
                             lx_ge(h1_lx_q[s], s), lx_ge(h2_lx_q[s], s)};
`ifdef SEG_EDGE_POS_EN
        edge_pos_d[22*s +: 22] = {h1_lx_q[s], h2_lx_q[s]};
`endif
        h1_win_d[s] = WIN_ONES;
        h2_win_d[s] = WIN_ONES;
        v_win_d[s]  = WIN_ONES;
        h1_cnt_d[s] = 2'd0;
        h2_cnt_d[s] = 2'd0;
        v_cnt_d[s]  = 2'd0;
        h1_lx_d[s]  = {LXW{1'b0}};
        h2_lx_d[s]  = {LXW{1'b0}};
        sat_any_d   = sat_flag_q;
        sat_flag_d  = 1'b0;
      end else begin
        if (on_y1_s & in_slot_s[s]) begin
          h1_win_d[s] = {h1_win_q[s][WIN-2:0], pix.pix_bin};
          h1_cnt_d[s] = bump(h1_win_d[s], h1_cnt_q[s]);
          sat_flag_d  = sat_flag_d | sat_hit(h1_win_d[s], h1_cnt_q[s]);
          h1_lx_d[s]  = (h1_win_d[s] == EDGE_PAT) ? lx_store(pix.pix_x, s) : h1_lx_q[s];
        end else if (on_y1_s & ~in_any_s) begin
          h1_win_d[s] = WIN_ONES;
        end else begin
          h1_win_d[s] = h1_win_q[s];
        end
        if (on_y2_s & in_slot_s[s]) begin
          h2_win_d[s] = {h2_win_q[s][WIN-2:0], pix.pix_bin};
          h2_cnt_d[s] = bump(h2_win_d[s], h2_cnt_q[s]);
          sat_flag_d  = sat_flag_d | sat_hit(h2_win_d[s], h2_cnt_q[s]);
          h2_lx_d[s]  = (h2_win_d[s] == EDGE_PAT) ? lx_store(pix.pix_x, s) : h2_lx_q[s];
        end else if (on_y2_s & ~in_any_s) begin
          h2_win_d[s] = WIN_ONES;
        end else begin
          h2_win_d[s] = h2_win_q[s];
        end
        if (in_band_s & (pix.pix_x == slot_cx(s))) begin
          v_win_d[s] = {v_win_q[s][WIN-2:0], pix.pix_bin};
          v_cnt_d[s] = bump(v_win_d[s], v_cnt_q[s]);
          sat_flag_d = sat_flag_d | sat_hit(v_win_d[s], v_cnt_q[s]);
        end else begin
          v_win_d[s] = v_win_q[s];
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        h1_win_q[s] <= WIN_ONES;
        h2_win_q[s] <= WIN_ONES;
        v_win_q[s]  <= WIN_ONES;
        h1_cnt_q[s] <= 2'd0;
        h2_cnt_q[s] <= 2'd0;
        v_cnt_q[s]  <= 2'd0;
        h1_lx_q[s]  <= {LXW{1'b0}};
        h2_lx_q[s]  <= {LXW{1'b0}};
      end
      sat_flag_q   <= 1'b0;
      codes_q      <= {(8*NUM_SLOTS){1'b0}};
      code_valid_q <= 1'b0;
      sat_any_q    <= 1'b0;
`ifdef SEG_EDGE_POS_EN
      edge_pos_q   <= {(22*NUM_SLOTS){1'b0}};
`endif
    end else begin
      h1_win_q     <= h1_win_d;
      h2_win_q     <= h2_win_d;
      v_win_q      <= v_win_d;
      h1_cnt_q     <= h1_cnt_d;
      h2_cnt_q     <= h2_cnt_d;
      v_cnt_q      <= v_cnt_d;
      h1_lx_q      <= h1_lx_d;
      h2_lx_q      <= h2_lx_d;
      sat_flag_q   <= sat_flag_d;
      codes_q      <= codes_d;
      code_valid_q <= code_valid_d;
      sat_any_q    <= sat_any_d;
`ifdef SEG_EDGE_POS_EN
      edge_pos_q   <= edge_pos_d;
`endif
    end
  end

  assign codes      = codes_q;
  assign code_valid = code_valid_q;
  assign sat_any    = sat_any_q;
`ifdef SEG_EDGE_POS_EN
  assign edge_pos   = edge_pos_q;
`endif
endmodule

// File: tb/tb_seg_scan_recognizer.sv
// Bench for seg_scan_recognizer: directed scenarios plus random bursts against a queue-based model.
module tb_seg_scan_recognizer;
  localparam int NS  = 3;
  localparam int X0  = 370;
  localparam int PIT = 200;
  localparam int SW  = 141;
  localparam int Y1  = 343;
  localparam int Y2  = 376;
  localparam int VB0 = 290;
  localparam int VB1 = 430;
  localparam int ER  = 4;
  localparam int RX  = 500;
  localparam int RY  = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8*NS-1:0] codes;
  logic code_valid;
  logic sat_any;
`ifdef SEG_EDGE_POS_EN
  logic [22*NS-1:0] edge_pos;
  logic [22*NS-1:0] exp_pos;
`endif

  seg_scan_recognizer_if bus ();

  seg_scan_recognizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (bus),
    .codes      (codes),
    .code_valid (code_valid),
`ifdef SEG_EDGE_POS_EN
    .edge_pos   (edge_pos),
`endif
    .sat_any    (sat_any)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: history of bits seen per scan structure; index s = h1, NS+s = h2, 2NS+s = v.
  bit   hist [3*NS][$];
  int   cnt  [3*NS];
  int   lastx [2*NS];
  bit   sat_m;
  logic [8*NS-1:0] exp_codes;
  logic exp_valid;
  logic exp_sat;

  function automatic int cx(input int s);
    return X0 + s * PIT + SW / 2;
  endfunction

  function automatic bit is_edge(input int k);
    int n;
    bit b;
    n = hist[k].size();
    for (int i = 0; i < 2 * ER; i++) begin
      b = (n - 1 - i >= 0) ? hist[k][n - 1 - i] : 1'b1;
      if (b != (i >= ER)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3 * NS; k++) begin
      hist[k].delete();
      cnt[k] = 0;
    end
    for (int k = 0; k < 2 * NS; k++) lastx[k] = 0;
    sat_m = 1'b0;
  endtask

  task automatic push(input int k, input bit b, input int x);
    hist[k].push_back(b);
    if (hist[k].size() > 2 * ER) hist[k].delete(0);
    if (is_edge(k)) begin
      if (cnt[k] == 3) sat_m = 1'b1;
      else cnt[k] = cnt[k] + 1;
      if (k < 2 * NS) lastx[k] = x;
    end
  endtask

  task automatic model_step(input bit en, input bit vde, input bit b, input int x, input int y);
    int slot;
    exp_valid = 1'b0;
    if (!(en && vde)) return;
    if (x == RX && y == RY) begin
      for (int s = 0; s < NS; s++) begin
        exp_codes[8*s +: 8] = {2'(cnt[s]), 2'(cnt[NS+s]), 2'(cnt[2*NS+s]),
                               lastx[s] >= cx(s), lastx[NS+s] >= cx(s)};
`ifdef SEG_EDGE_POS_EN
        exp_pos[22*s +: 22] = {11'(lastx[s]), 11'(lastx[NS+s])};
`endif
      end
      exp_sat   = sat_m;
      exp_valid = 1'b1;
      model_clear();
      return;
    end
    slot = -1;
    for (int s = 0; s < NS; s++)
      if (x >= X0 + s * PIT && x <= X0 + s * PIT + SW - 1) slot = s;
    if (y == Y1) begin
      if (slot >= 0) push(slot, b, x);
      else for (int s = 0; s < NS; s++) hist[s].delete();
    end
    if (y == Y2) begin
      if (slot >= 0) push(NS + slot, b, x);
      else for (int s = 0; s < NS; s++) hist[NS+s].delete();
    end
    if (y >= VB0 && y <= VB1)
      for (int s = 0; s < NS; s++) if (x == cx(s)) push(2 * NS + s, b, x);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".code_valid"}, 128'(code_valid), 128'(exp_valid));
    chk({tag, ".codes"}, 128'(codes), 128'(exp_codes));
    chk({tag, ".sat_any"}, 128'(sat_any), 128'(exp_sat));
`ifdef SEG_EDGE_POS_EN
    chk({tag, ".edge_pos"}, 128'(edge_pos), 128'(exp_pos));
`endif
  endtask

  task automatic pixel(input bit en, input bit vde, input bit b, input int x, input int y);
    @(negedge clk);
    bus.pix_en  = en;
    bus.pix_vde = vde;
    bus.pix_bin = b;
    bus.pix_x   = 11'(x);
    bus.pix_y   = 10'(y);
    @(posedge clk);
    model_step(en, vde, b, x, y);
    #1;
    check_outputs("px");
  endtask

  task automatic report();
    pixel(1'b1, 1'b1, 1'b1, RX, RY);
  endtask

  // n1 ones then n0 zeros along a line (dx=1) or a column (dy=1), optionally with ignored filler cycles.
  task automatic run(input int x, input int y, input int dx, input int dy,
                     input int n1, input int n0, input bit gated);
    for (int i = 0; i < n1 + n0; i++) begin
      if (gated) begin
        pixel(1'b0, 1'b1, 1'($urandom), x, y);
        pixel(1'b1, 1'b0, 1'($urandom), x, y);
      end
      pixel(1'b1, 1'b1, (i < n1) ? 1'b1 : 1'b0, x, y);
      x = x + dx;
      y = y + dy;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    exp_codes = '0;
    exp_valid = 1'b0;
    exp_sat   = 1'b0;
`ifdef SEG_EDGE_POS_EN
    exp_pos   = '0;
`endif
    #1;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int kind, s, x, y, dx, dy, len, runleft;
    bit cur, en, vde;
    bus.pix_en = 1'b0; bus.pix_vde = 1'b0; bus.pix_bin = 1'b1;
    bus.pix_x = 11'd0; bus.pix_y = 10'd0;
    do_reset();

    // Partial stroke, reset mid-stream, then a background-only frame.
    run(380, Y1, 1, 0, 4, 2, 1'b0);
    do_reset();
    run(380, Y1, 1, 0, 8, 0, 1'b0);
    report();
    chk("bg_after_reset", 128'(codes), 128'(0));

    // Single edge on slot 0, upper line.
    run(380, Y1, 1, 0, 4, 4, 1'b0);
    report();
    chk("single_h1_slot0", 128'(codes[7:0]), 128'(8'h40));
    pixel(1'b0, 1'b0, 1'b0, 0, 0);
    chk("valid_one_cycle", 128'(code_valid), 128'(0));

    // Side bit on slot 2, lower line.
    run(850, Y2, 1, 0, 4, 4, 1'b0);
    report();
    chk("side_h2_slot2", 128'(codes[23:16]), 128'(8'h11));

    // Vertical column saturation.
    run(640, 300, 0, 1, 4, 4, 1'b0);
    run(640, 308, 0, 1, 4, 4, 1'b0);
    run(640, 316, 0, 1, 4, 4, 1'b0);
    report();
    chk("v_three", 128'(codes[15:8]), 128'(8'h0C));
    chk("v_three_sat", 128'(sat_any), 128'(0));
    for (int r = 0; r < 4; r++) run(640, 300 + 8 * r, 0, 1, 4, 4, 1'b0);
    report();
    chk("v_four", 128'(codes[15:8]), 128'(8'h0C));
    chk("v_four_sat", 128'(sat_any), 128'(1));

    // Gated stream must match the gap-free single edge.
    run(380, Y1, 1, 0, 4, 4, 1'b1);
    report();
    chk("gated_h1_slot0", 128'(codes[7:0]), 128'(8'h40));

    // Gap pixel between slots resets windows.
    run(380, Y1, 1, 0, 4, 2, 1'b0);
    pixel(1'b1, 1'b1, 1'b1, 520, Y1);
    run(386, Y1, 1, 0, 0, 2, 1'b0);
    report();
    chk("gap_reset_slot0", 128'(codes[7:0]), 128'(0));
    run(380, Y1, 1, 0, 4, 0, 1'b0);
    pixel(1'b1, 1'b1, 1'b1, 520, Y1);
    run(590, Y1, 1, 0, 0, 4, 1'b0);
    report();

    // Random bursts.
    for (int f = 0; f < 14; f++) begin
      if (f == 6) do_reset();
      for (int bu = 0; bu < 10; bu++) begin
        kind = $urandom_range(0, 3);
        s    = $urandom_range(0, NS - 1);
        len  = $urandom_range(6, 16);
        dx = 1; dy = 0;
        x  = X0 + s * PIT + $urandom_range(0, SW - 1);
        if ($urandom_range(0, 3) == 0) x = $urandom_range(360, 920);
        case (kind)
          0: y = Y1;
          1: y = Y2;
          2: begin
            y = $urandom_range(VB0, VB1);
            x = cx(s) + (($urandom_range(0, 7) == 0) ? 1 : 0);
            dx = 0; dy = 1;
          end
          default: y = $urandom_range(0, VB0 - 1);
        endcase
        cur = 1'b1;
        runleft = $urandom_range(3, 5);
        for (int i = 0; i < len; i++) begin
          en  = ($urandom_range(0, 7) != 0);
          vde = ($urandom_range(0, 15) != 0);
          pixel(en, vde, (en && vde) ? cur : 1'($urandom), x, y);
          if (en && vde) begin
            runleft = runleft - 1;
            if (runleft == 0) begin
              cur = ~cur;
              runleft = $urandom_range(3, 5);
            end
          end
          x = x + dx;
          y = y + dy;
        end
        if ($urandom_range(0, 9) == 0) report();
      end
      report();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
